// File: rtl/dsp_post_accumulator.sv
// DSP48A1 post-adder/accumulator: M register, X/Z operand muxes,
// 48-bit add/sub into P with carry, sticky signed overflow, valid pipe.
//
// Ports:
//   clk, rst_n (async, active-low), rst_p (sync reset)
//   ce_m, ce_p      : stage clock enables
//   valid_in, m_in  : product and its valid marker
//   c_in, pcin      : C operand and cascade input
//   opmode          : [1:0] X sel, [3:2] Z sel, [4] subtract
//   carryin         : post-adder carry in
//   p_out, pcout    : P register (pcout mirrors p_out)
//   carryout        : registered carry/borrow
//   overflow        : sticky signed overflow
//   valid_out       : p_out holds a result from a valid input
module dsp_post_accumulator #(
   parameter int P_WIDTH = 48,
   parameter int M_WIDTH = 36
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rst_p,
   input  logic               ce_m,
   input  logic               ce_p,
   input  logic               valid_in,
   input  logic [M_WIDTH-1:0] m_in,
   input  logic [P_WIDTH-1:0] c_in,
   input  logic [P_WIDTH-1:0] pcin,
   input  logic [4:0]         opmode,
   input  logic               carryin,
   output logic [P_WIDTH-1:0] p_out,
   output logic [P_WIDTH-1:0] pcout,
   output logic               carryout,
   output logic               overflow,
   output logic               valid_out
);

   localparam int MSB = P_WIDTH - 1;

   logic [M_WIDTH-1:0] m_reg;
   logic               vm;
   logic [P_WIDTH-1:0] x;
   logic [P_WIDTH-1:0] z;
   logic [P_WIDTH:0]   xe;
   logic [P_WIDTH:0]   sum;
   logic               ovf_now;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reg <= '0;
         vm    <= 1'b0;
      end else if (rst_p) begin
         m_reg <= '0;
         vm    <= 1'b0;
      end else if (ce_m) begin
         m_reg <= m_in;
         vm    <= valid_in;
      end
   end

   always_comb begin
      x = '0;
      unique case (opmode[1:0])
         2'd0: x = '0;
         2'd1: x[M_WIDTH-1:0] = m_reg;
         2'd2: x = p_out;
         2'd3: begin
            // upper bits come from C, low bits from the product
            x = c_in;
            x[M_WIDTH-1:0] = m_reg;
         end
         default: x = '0;
      endcase
   end

   always_comb begin
      z = '0;
      unique case (opmode[3:2])
         2'd0: z = '0;
         2'd1: z = pcin;
         2'd2: z = p_out;
         2'd3: z = c_in;
         default: z = '0;
      endcase
   end

   always_comb begin
      xe = {1'b0, x} + {{P_WIDTH{1'b0}}, carryin};
      if (opmode[4]) begin
         sum     = {1'b0, z} - xe;
         ovf_now = (z[MSB] != x[MSB]) && (sum[MSB] != z[MSB]);
      end else begin
         sum     = {1'b0, z} + xe;
         ovf_now = (z[MSB] == x[MSB]) && (sum[MSB] != z[MSB]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_out     <= '0;
         carryout  <= 1'b0;
         overflow  <= 1'b0;
         valid_out <= 1'b0;
      end else if (rst_p) begin
         p_out     <= '0;
         carryout  <= 1'b0;
         overflow  <= 1'b0;
         valid_out <= 1'b0;
      end else if (ce_p) begin
         p_out     <= sum[P_WIDTH-1:0];
         carryout  <= sum[P_WIDTH];
         overflow  <= overflow | ovf_now;
         valid_out <= vm;
      end
   end

   assign pcout = p_out;

endmodule

// File: tb/tb_dsp_post_accumulator.sv
// Directed bench for dsp_post_accumulator: pipeline, accumulate,
// subtract, sticky overflow, cascade, sync and async resets.
module tb_dsp_post_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rst_p;
   logic        ce_m;
   logic        ce_p;
   logic        valid_in;
   logic [35:0] m_in;
   logic [47:0] c_in;
   logic [47:0] pcin;
   logic [4:0]  opmode;
   logic        carryin;
   logic [47:0] p_out;
   logic [47:0] pcout;
   logic        carryout;
   logic        overflow;
   logic        valid_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dsp_post_accumulator #(.P_WIDTH(48), .M_WIDTH(36)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rst_p(rst_p),
      .ce_m(ce_m),
      .ce_p(ce_p),
      .valid_in(valid_in),
      .m_in(m_in),
      .c_in(c_in),
      .pcin(pcin),
      .opmode(opmode),
      .carryin(carryin),
      .p_out(p_out),
      .pcout(pcout),
      .carryout(carryout),
      .overflow(overflow),
      .valid_out(valid_out)
   );

   task automatic chk(input string tag, input logic [47:0] obs,
                      input logic [47:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " p"}, p_out, 48'd0);
      chk({tag, " pcout"}, pcout, 48'd0);
      chk({tag, " co"}, {47'd0, carryout}, 48'd0);
      chk({tag, " ovf"}, {47'd0, overflow}, 48'd0);
      chk({tag, " vo"}, {47'd0, valid_out}, 48'd0);
   endtask

   initial begin
      rst_n = 1'b0; rst_p = 1'b0;
      ce_m = 1'b1; ce_p = 1'b1;
      valid_in = 1'b0; m_in = '0;
      c_in = '0; pcin = '0;
      opmode = '0; carryin = 1'b0;
      #3;
      chk_all_zero("reset");

      // two-cycle pipeline
      @(negedge clk);
      rst_n = 1'b1;
      opmode = 5'b0_11_01;
      m_in = 36'd1000; c_in = 48'd24;
      carryin = 1'b1; valid_in = 1'b1;
      step();
      chk("pipe e1 p", p_out, 48'd25);
      chk("pipe e1 vo", {47'd0, valid_out}, 48'd0);
      step();
      chk("pipe p", p_out, 48'd1025);
      chk("pipe co", {47'd0, carryout}, 48'd0);
      chk("pipe vo", {47'd0, valid_out}, 48'd1);

      // accumulate 5 per cycle
      rst_p = 1'b1;
      step();
      chk("rstp p", p_out, 48'd0);
      chk("rstp vo", {47'd0, valid_out}, 48'd0);
      rst_p = 1'b0; ce_p = 1'b0;
      opmode = 5'b0_10_01; m_in = 36'd5; carryin = 1'b0;
      step();
      chk("preload hold p", p_out, 48'd0);
      ce_p = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("acc %0d", i), p_out, 48'(5 * i));
      end
      chk("acc vo", {47'd0, valid_out}, 48'd1);
      ce_p = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold %0d", i), p_out, 48'd20);
      end

      // subtract with borrow: 3 - 5
      ce_p = 1'b1;
      opmode = 5'b1_11_01; c_in = 48'd3;
      step();
      chk("sub p", p_out, 48'hFFFF_FFFF_FFFE);
      chk("sub co", {47'd0, carryout}, 48'd1);
      chk("sub ovf", {47'd0, overflow}, 48'd0);

      // sticky signed overflow
      ce_p = 1'b0; m_in = 36'd1;
      step();
      ce_p = 1'b1;
      opmode = 5'b0_11_01; c_in = 48'h7FFF_FFFF_FFFF;
      step();
      chk("ovf p", p_out, 48'h8000_0000_0000);
      chk("ovf set", {47'd0, overflow}, 48'd1);
      chk("ovf co", {47'd0, carryout}, 48'd0);
      c_in = 48'd10;
      step();
      chk("ovf add p", p_out, 48'd11);
      chk("ovf sticky", {47'd0, overflow}, 48'd1);
      rst_p = 1'b1;
      step();
      chk("ovf clr", {47'd0, overflow}, 48'd0);
      chk("ovf clr p", p_out, 48'd0);
      rst_p = 1'b0;

      // cascade, then rst_p beats ce_p
      opmode = 5'b0_01_00;
      pcin = 48'h0000_0001_0000; carryin = 1'b1;
      step();
      chk("casc p", p_out, 48'h0000_0001_0001);
      chk("casc pcout", pcout, 48'h0000_0001_0001);
      rst_p = 1'b1;
      step();
      chk("prio p", p_out, 48'd0);
      rst_p = 1'b0;

      // async reset mid-accumulation
      opmode = 5'b0_10_01; carryin = 1'b0; m_in = 36'd1;
      step();
      step();
      step();
      chk("pre async p", p_out, 48'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async");
      #1;
      rst_n = 1'b1; m_in = 36'd7;
      #3;
      chk_all_zero("async held");
      step();
      chk("post e1 p", p_out, 48'd0);
      chk("post e1 vo", {47'd0, valid_out}, 48'd0);
      step();
      chk("post e2 p", p_out, 48'd7);
      chk("post e2 vo", {47'd0, valid_out}, 48'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_post_accumulator.md
# dsp_post_accumulator

Downstream post-adder/accumulator stage of the DSP48A1 datapath. It registers the 36-bit multiplier product (M register), selects X/Z operands through opmode-controlled muxes, and adds or subtracts them into a 48-bit P register with carry-in, carry-out and accumulate feedback. It produces the block's final P, CARRYOUT and PCOUT outputs, plus a sticky signed-overflow flag and a valid pipeline marker.

## Interface
- `P_WIDTH`, 48, P/C/PCIN datapath width
- `M_WIDTH`, 36, multiplier product width; must be at most `P_WIDTH`
- `clk` input 1: single clock; all state on rising edge
- `rst_n` input 1: asynchronous, active-low reset of all state
- `rst_p` input 1: synchronous reset of M register, P register, CARRYOUT, overflow flag and valid pipe
- `ce_m` input 1: clock enable, M stage
- `ce_p` input 1: clock enable, P stage (P, CARRYOUT, overflow, valid_out)
- `valid_in` input 1: marks a product on `m_in`
- `m_in` input M_WIDTH: unsigned multiplier product
- `c_in` input P_WIDTH: C operand
- `pcin` input P_WIDTH: cascade input from previous slice
- `opmode` input 5: [1:0] X select, [3:2] Z select, [4] subtract
- `carryin` input 1: carry into post-adder
- `p_out` output P_WIDTH: P register
- `pcout` output P_WIDTH: equal to `p_out`, for cascade
- `carryout` output 1: registered post-adder carry or borrow
- `overflow` output 1: sticky signed overflow
- `valid_out` output 1: `p_out` holds a result from a valid input

## Operation
- M stage: when `ce_m` = 1, load `m_reg <= m_in` and `vm <= valid_in`.
- X mux, decoded from `opmode[1:0]`:
  - 0: X = 0
  - 1: X = zero-extended `m_reg`
  - 2: X = `p_out`
  - 3: X = `{c_in[P_WIDTH-1:M_WIDTH], m_reg}`
- Z mux, decoded from `opmode[3:2]`:
  - 0: Z = 0
  - 1: Z = `pcin`
  - 2: Z = `p_out` (accumulate)
  - 3: Z = `c_in`
- Add/subtract, computed (P_WIDTH+1) bits wide:
  - `opmode[4]` = 0: sum = Z + (X + carryin)
  - `opmode[4]` = 1: sum = Z − (X + carryin)
  - P gets sum[P_WIDTH-1:0]; CARRYOUT gets sum[P_WIDTH].
- Signed overflow is detected on the MSB:
  - add: Z and X have the same sign and the result sign differs.
  - subtract: Z and X have opposite signs and the result sign differs from Z.
  - Once set, `overflow` stays set until `rst_p` or `rst_n`. P still wraps modulo 2^P_WIDTH; it is never saturated.
- `opmode`, `c_in`, `pcin` and `carryin` are unregistered and sampled at the P-stage edge.
- Priority per stage: `rst_n` > `rst_p` > `ce` = 0 (hold) > load.

## Timing
- Reset values: `p_out` = 0, `pcout` = 0, `carryout` = 0, `overflow` = 0, `valid_out` = 0, `m_reg` = 0, `vm` = 0.
- Latency: `m_in` to `p_out` is 2 cycles with both enables high; `c_in`/`pcin`/`opmode` to `p_out` is 1 cycle.
- Accumulate (Z = P) uses the P value held before the current edge, so back-to-back accumulation sustains 1 result per cycle.
- `ce_p` = 0: P, CARRYOUT, overflow and `valid_out` hold. `ce_m` = 0: M and `vm` hold. A stalled M stage with `ce_p` = 1 re-adds the same `m_reg` each cycle; this is legal and intended for constant-step accumulation.
- `valid_out` <= `vm` on each P-stage load.
- `rst_p` asserted on the same edge as `ce_p` = 1: reset wins, P = 0.
- `rst_n` asserted mid-accumulation clears everything immediately, without waiting for a clock edge. After release, the first edge behaves as a normal load.

## Test plan
- Async reset mid-run:
  - Stimulus: pulse `rst_n` low between edges while accumulating.
  - Required response: all outputs are 0 immediately and remain 0 until the next load.
- Two-cycle pipeline:
  - Stimulus: opmode = 5'b0_11_01, `m_in` = 36'd1000, `c_in` = 48'd24, `carryin` = 1.
  - Required response: two edges later `p_out` = 1025, `carryout` = 0, `valid_out` = 1.
- Accumulate:
  - Stimulus: opmode = 5'b0_10_01, `m_in` held at 5, both enables high, 4 results.
  - Required response: `p_out` reads 5, 10, 15, 20.
  - Then `ce_p` = 0 for 3 cycles: `p_out` stays 20.
- Subtract with borrow:
  - Stimulus: opmode = 5'b1_11_01, `c_in` = 3, `m_reg` = 5, `carryin` = 0.
  - Required response: `p_out` = 48'hFFFF_FFFF_FFFE, `carryout` = 1, `overflow` = 0.
- Signed overflow sticky:
  - Stimulus: `c_in` = 48'h7FFF_FFFF_FFFF, X = `m_reg` = 1, add.
  - Required response: `p_out` = 48'h8000_0000_0000 and `overflow` = 1.
  - Then a normal add: `overflow` stays 1. Then `rst_p`: `overflow` = 0 and P = 0.
- Cascade and priority:
  - Stimulus: Z = `pcin` = 48'h0000_0001_0000, X = 0, `carryin` = 1.
  - Required response: `p_out` = `pcout` = 48'h0000_0001_0001.
  - With `rst_p` = 1 and `ce_p` = 1 on the same edge: P = 0.
